// File: rtl/demux_1to4_pkg.sv
// Shared types and constants for the 1-to-4 demultiplexer.
package demux_1to4_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_Y0 = 2'd0;
    localparam sel_t SEL_Y1 = 2'd1;
    localparam sel_t SEL_Y2 = 2'd2;
    localparam sel_t SEL_Y3 = 2'd3;

    localparam int NUM_LANES = 4;

endpackage

// File: rtl/demux_1to4_decode.sv
// Combinational 2->4 one-hot decoder with enable.
// The output is all-zero when disabled or when sel is unknown.
module demux_1to4_decode
    import demux_1to4_pkg::*;
(
    input  logic                 en,
    input  sel_t                 sel,
    output logic [NUM_LANES-1:0] hot
);

    // Decode the select into one hot bit.
    // An X/Z select matches no item, so it falls through to the zero default.
    always_comb begin
        hot = '0;
        if (en) begin
            case (sel)
                SEL_Y0:  hot = 4'b0001;
                SEL_Y1:  hot = 4'b0010;
                SEL_Y2:  hot = 4'b0100;
                SEL_Y3:  hot = 4'b1000;
                default: hot = '0;
            endcase
        end
    end

endmodule

// File: rtl/demux_1to4.sv
// 1-to-4 demultiplexer with per-lane valid.
// The output stage is either registered (1-cycle latency) or combinational.
module demux_1to4
    import demux_1to4_pkg::*;
#(
    parameter int DATA_W     = 1,
    parameter bit REGISTERED = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  sel_t              sel,
    input  logic [DATA_W-1:0] i,
    input  logic              in_valid,
    output logic [DATA_W-1:0] y0,
    output logic [DATA_W-1:0] y1,
    output logic [DATA_W-1:0] y2,
    output logic [DATA_W-1:0] y3,
    output logic [3:0]        y_valid
);

    if (DATA_W < 1) begin : g_bad_width
        $error("demux_1to4: DATA_W must be >= 1");
    end

    logic [NUM_LANES-1:0]             hot;
    logic [NUM_LANES-1:0][DATA_W-1:0] lane_d;
    logic [NUM_LANES-1:0][DATA_W-1:0] lane_q;
    logic [NUM_LANES-1:0]             vld_q;

    demux_1to4_decode u_dec (
        .en  (in_valid),
        .sel (sel),
        .hot (hot)
    );

    // Only the hot lane carries the data; every other lane is forced to zero.
    for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
        assign lane_d[n] = hot[n] ? i : '0;
    end

    if (REGISTERED) begin : g_reg
        // Output flops. Reset wins over any incoming transfer.
        always_ff @(posedge clk) begin
            if (rst) begin
                lane_q <= '0;
                vld_q  <= '0;
            end else begin
                lane_q <= lane_d;
                vld_q  <= hot;
            end
        end

        a_rst_clears: assert property (@(posedge clk) rst |=> (vld_q == '0 && lane_q == '0));
    end else begin : g_comb
        assign lane_q = lane_d;
        assign vld_q  = hot;

        // clk and rst have no function in this mode.
        logic unused_clk_rst;
        assign unused_clk_rst = ^{clk, rst};
    end

    assign y0      = lane_q[0];
    assign y1      = lane_q[1];
    assign y2      = lane_q[2];
    assign y3      = lane_q[3];
    assign y_valid = vld_q;

    a_onehot0: assert property (@(posedge clk) $onehot0(y_valid));

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_chk
        a_idle_zero: assert property (@(posedge clk) !y_valid[n] |-> lane_q[n] == '0);
    end

endmodule

// File: tb/tb_demux_1to4.sv
// Scoreboard bench for demux_1to4.
// It exercises a registered 8-bit instance, a registered 1-bit instance and a
// combinational 8-bit instance.
module tb_demux_1to4;
    import demux_1to4_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst      = 1'b0;
    logic       in_valid = 1'b0;
    sel_t       sel      = '0;
    logic [7:0] i        = '0;

    logic [7:0] r0, r1, r2, r3;
    logic [3:0] rv;
    logic [7:0] c0, c1, c2, c3;
    logic [3:0] cv;
    logic       w0, w1, w2, w3;
    logic [3:0] wv;

    demux_1to4 #(.DATA_W(8), .REGISTERED(1)) u_reg (
        .clk(clk), .rst(rst), .sel(sel), .i(i), .in_valid(in_valid),
        .y0(r0), .y1(r1), .y2(r2), .y3(r3), .y_valid(rv)
    );

    demux_1to4 #(.DATA_W(1), .REGISTERED(1)) u_reg1 (
        .clk(clk), .rst(rst), .sel(sel), .i(i[0]), .in_valid(in_valid),
        .y0(w0), .y1(w1), .y2(w2), .y3(w3), .y_valid(wv)
    );

    demux_1to4 #(.DATA_W(8), .REGISTERED(0)) u_comb (
        .clk(clk), .rst(rst), .sel(sel), .i(i), .in_valid(in_valid),
        .y0(c0), .y1(c1), .y2(c2), .y3(c3), .y_valid(cv)
    );

    typedef struct packed {
        logic [3:0][7:0] y;
        logic [3:0]      v;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    // Reference behaviour: one selected lane carries the data, all others are zero.
    function automatic exp_t model(logic r, logic vld, logic [1:0] s, logic [7:0] d);
        exp_t e;
        e.y = '0;
        e.v = '0;
        if (!r && vld) begin
            e.y[s] = d;
            e.v[s] = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, queue the registered expectation,
    // and check the combinational instance immediately.
    task automatic apply(logic r, logic v, logic [1:0] s, logic [7:0] d);
        exp_t e;
        logic [3:0][7:0] cy;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        sel      = s;
        i        = d;
        q.push_back(model(r, v, s, d));
        #1;
        e  = model(1'b0, v, s, d);
        cy = {c3, c2, c1, c0};
        for (int n = 0; n < 4; n++)
            chk($sformatf("comb_y%0d", n), {24'b0, cy[n]}, {24'b0, e.y[n]});
        chk("comb_valid", {28'b0, cv}, {28'b0, e.v});
    endtask

    // Monitor: each edge, compare registered outputs against the oldest expectation.
    initial begin
        exp_t e;
        logic [3:0][7:0] ry;
        logic [3:0]      wy;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e  = q.pop_front();
                ry = {r3, r2, r1, r0};
                wy = {w3, w2, w1, w0};
                for (int n = 0; n < 4; n++) begin
                    chk($sformatf("reg_y%0d", n), {24'b0, ry[n]}, {24'b0, e.y[n]});
                    chk($sformatf("w1_y%0d", n), {31'b0, wy[n]}, {31'b0, e.y[n][0]});
                end
                chk("reg_valid", {28'b0, rv}, {28'b0, e.v});
                chk("w1_valid", {28'b0, wv}, {28'b0, e.v});
                chk("reg_onehot0", {31'b0, $onehot0(rv)}, 32'd1);
            end
        end
    end

    initial begin
        // Reset with a competing valid transfer
        apply(1'b1, 1'b1, 2'b10, 8'h01);
        apply(1'b1, 1'b1, 2'b10, 8'h01);
        // Lane sweep, each select held for two cycles
        for (int s = 0; s < 4; s++) begin
            apply(1'b0, 1'b1, s[1:0], 8'h01);
            apply(1'b0, 1'b1, s[1:0], 8'h01);
        end
        // Zero data still flags the lane as valid
        apply(1'b0, 1'b1, 2'b01, 8'h00);
        // Valid gating
        apply(1'b0, 1'b0, 2'b11, 8'h01);
        // Wide data with back-to-back lane switch
        apply(1'b0, 1'b1, 2'b00, 8'hA5);
        apply(1'b0, 1'b1, 2'b11, 8'h3C);
        apply(1'b0, 1'b0, 2'b00, 8'h00);
        // Reset mid-stream drops the in-flight transfer
        apply(1'b0, 1'b1, 2'b10, 8'hFF);
        apply(1'b1, 1'b1, 2'b01, 8'hEE);
        apply(1'b0, 1'b1, 2'b01, 8'h77);
        // Random traffic
        for (int k = 0; k < 300; k++)
            apply(($urandom_range(15) == 0), $urandom_range(1) == 1,
                  2'($urandom_range(3)), 8'($urandom));
        apply(1'b0, 1'b0, 2'b00, 8'h00);
        repeat (3) @(posedge clk);
        #2;
        chk("drain", q.size(), 32'd0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
